// File: rtl/rd_resp_route.sv
// rd_resp_route: tags cache-RAM reads per hash, buffers returned data and
// routes it back to the issuing channel through per-channel round-robin.
module rd_resp_route #(
  parameter int RAM_RD_LAT = 2,
  parameter int DATA_W = 128,
  parameter int TXN_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             v_cmd_vld,
  input  logic [3:0][2:0]        v_cmd_src,
  input  logic [3:0]             v_cmd_ram_sel,
  input  logic [3:0][TXN_W-1:0]  v_cmd_txn_id,
  output logic [3:0]             v_cmd_credit_ok,
  input  logic [7:0]             ram_rd_data_vld,
  input  logic [7:0][DATA_W-1:0] ram_rd_data,
  output logic [4:0]             v_resp_vld,
  input  logic [4:0]             v_resp_rdy,
  output logic [4:0][DATA_W-1:0] v_resp_data,
  output logic [4:0][TXN_W-1:0]  v_resp_txn_id,
  output logic                   rd_resp_err
);
  localparam int L = RAM_RD_LAT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(L + 1);

  logic [L-1:0]      tv [4];
  logic [L-1:0]      tsel [4];
  logic [2:0]        tsrc [4][L];
  logic [TXN_W-1:0]  ttxn [4][L];
  logic [2:0]        msrc [4][FIFO_DEPTH];
  logic [TXN_W-1:0]  mtxn [4][FIFO_DEPTH];
  logic [DATA_W-1:0] mdata [4][FIFO_DEPTH];
  logic [CW-1:0]     wp [4], rp [4], cnt [4];
  logic [1:0]        ptr [5], lock_i [5], gnt [5];
  logic [4:0]        lock_v;
  logic [3:0]        push, pop;
  logic [BW-1:0]     blank;
  logic [7:0]        load;
  logic [1:0]        idx;
  logic              err_set;

  always_comb begin
    load = '0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = wp[i] - rp[i];
      load = 8'(cnt[i]) + 8'($countones(tv[i]));
      v_cmd_credit_ok[i] = load < 8'(FIFO_DEPTH);
    end
  end

  // a presented response stays locked to its hash until taken
  always_comb begin
    v_resp_vld = '0;
    v_resp_data = '0;
    v_resp_txn_id = '0;
    pop = '0;
    idx = '0;
    for (int d = 0; d < 5; d++) begin
      gnt[d] = '0;
      for (int k = 3; k >= 0; k--) begin
        idx = ptr[d] + 2'(k);
        if (cnt[idx] != '0 && msrc[idx][rp[idx][AW-1:0]] == 3'(d)) begin
          v_resp_vld[d] = 1'b1;
          gnt[d] = idx;
        end
      end
      if (lock_v[d]) begin
        v_resp_vld[d] = 1'b1;
        gnt[d] = lock_i[d];
      end
      if (v_resp_vld[d]) begin
        v_resp_data[d] = mdata[gnt[d]][rp[gnt[d]][AW-1:0]];
        v_resp_txn_id[d] = mtxn[gnt[d]][rp[gnt[d]][AW-1:0]];
      end
      if (v_resp_vld[d] && v_resp_rdy[d]) pop[gnt[d]] = 1'b1;
    end
  end

  always_comb begin
    push = '0;
    err_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tv[i][L-1] && ram_rd_data_vld[{2'(i), tsel[i][L-1]}])
        push[i] = cnt[i] != CW'(FIFO_DEPTH) || pop[i];
      err_set = err_set | (tv[i][L-1] && !push[i]);
      for (int j = 0; j < 2; j++)
        err_set = err_set | (ram_rd_data_vld[{2'(i), 1'(j)}] && blank == '0 &&
                             !(tv[i][L-1] && tsel[i][L-1] == 1'(j)));
      err_set = err_set | (v_cmd_vld[i] && (!v_cmd_credit_ok[i] || v_cmd_src[i] > 3'd4));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        tv[i] <= '0;
        wp[i] <= '0;
        rp[i] <= '0;
      end
      for (int d = 0; d < 5; d++) begin
        ptr[d] <= '0;
        lock_i[d] <= '0;
      end
      lock_v <= '0;
      blank <= BW'(L);
      rd_resp_err <= 1'b0;
    end else begin
      blank <= blank - BW'(blank != '0);
      rd_resp_err <= rd_resp_err | err_set;
      lock_v <= v_resp_vld & ~v_resp_rdy;
      for (int i = 0; i < 4; i++) begin
        tv[i][0] <= v_cmd_vld[i] && v_cmd_src[i] <= 3'd4;
        for (int j = 1; j < L; j++) tv[i][j] <= tv[i][j-1];
        wp[i] <= wp[i] + CW'(push[i]);
        rp[i] <= rp[i] + CW'(pop[i]);
      end
      for (int d = 0; d < 5; d++) begin
        lock_i[d] <= gnt[d];
        if (v_resp_vld[d] && v_resp_rdy[d]) ptr[d] <= gnt[d] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      tsrc[i][0] <= v_cmd_src[i];
      tsel[i][0] <= v_cmd_ram_sel[i];
      ttxn[i][0] <= v_cmd_txn_id[i];
      for (int j = 1; j < L; j++) begin
        tsrc[i][j] <= tsrc[i][j-1];
        tsel[i][j] <= tsel[i][j-1];
        ttxn[i][j] <= ttxn[i][j-1];
      end
      if (push[i]) begin
        msrc[i][wp[i][AW-1:0]] <= tsrc[i][L-1];
        mtxn[i][wp[i][AW-1:0]] <= ttxn[i][L-1];
        mdata[i][wp[i][AW-1:0]] <= ram_rd_data[{2'(i), tsel[i][L-1]}];
      end
    end
  end
endmodule

// File: tb/tb_rd_resp_route.sv
// tb_rd_resp_route: directed scenario tasks with hand-computed expectations.
module tb_rd_resp_route;
  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        cmd_vld;
  logic [3:0][2:0]   cmd_src;
  logic [3:0]        cmd_sel;
  logic [3:0][7:0]   cmd_txn;
  logic [3:0]        credit;
  logic [7:0]        dvld;
  logic [7:0][127:0] rdata;
  logic [4:0]        rvld;
  logic [4:0]        rdy;
  logic [4:0][127:0] rdat;
  logic [4:0][7:0]   rtxn;
  logic              err;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rd_resp_route dut (
    .clk(clk), .rst(rst),
    .v_cmd_vld(cmd_vld), .v_cmd_src(cmd_src), .v_cmd_ram_sel(cmd_sel),
    .v_cmd_txn_id(cmd_txn), .v_cmd_credit_ok(credit),
    .ram_rd_data_vld(dvld), .ram_rd_data(rdata),
    .v_resp_vld(rvld), .v_resp_rdy(rdy), .v_resp_data(rdat),
    .v_resp_txn_id(rtxn), .rd_resp_err(err)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    cmd_vld = '0;
    cmd_src = '0;
    cmd_sel = '0;
    cmd_txn = '0;
    dvld = '0;
    rdata = '0;
    rdy = 5'h1F;
    cyc;
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    reset_dut;
    #1;
    n_chk++; if (rvld !== 5'h0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", rvld); end
    n_chk++; if (credit !== 4'hF) begin n_fail++; $display("FAIL reset_credit got %h exp f", credit); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_chk++; if (rdat !== '0 || rtxn !== '0) begin n_fail++; $display("FAIL reset_data nonzero"); end
  endtask

  task automatic test_single;
    reset_dut;
    cmd_vld = 4'b0010; cmd_src[1] = 3'd2; cmd_sel[1] = 1'b1; cmd_txn[1] = 8'h5A;
    cyc;
    cmd_vld = '0;
    cyc;
    dvld = 8'b0000_1000; rdata[3] = 128'hDEAD;
    #1;
    n_chk++; if (rvld !== 5'h0) begin n_fail++; $display("FAIL single_early got %b exp 0", rvld); end
    cyc;
    dvld = '0;
    #1;
    n_chk++; if (rvld !== 5'b00100) begin n_fail++; $display("FAIL single_vld got %b exp 00100", rvld); end
    n_chk++; if (rdat[2] !== 128'hDEAD) begin n_fail++; $display("FAIL single_data got %h exp dead", rdat[2]); end
    n_chk++; if (rtxn[2] !== 8'h5A) begin n_fail++; $display("FAIL single_txn got %h exp 5a", rtxn[2]); end
    cyc;
    #1;
    n_chk++; if (rvld !== 5'h0) begin n_fail++; $display("FAIL single_pop got %b exp 0", rvld); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err got %b exp 0", err); end
  endtask

  task automatic test_fill_credit;
    reset_dut;
    rdy = 5'b11110;
    for (int n = 0; n < 7; n++) begin
      cmd_vld = (n < 4) ? 4'b0001 : 4'b0000;
      cmd_src[0] = 3'd0; cmd_sel[0] = 1'b0; cmd_txn[0] = 8'(8'h10 + n);
      dvld = (n >= 2 && n <= 5) ? 8'h01 : 8'h00;
      rdata[0] = 128'(100 + n - 2);
      #1;
      n_chk++; if (credit[0] !== (n < 4)) begin n_fail++; $display("FAIL fill_credit cyc %0d got %b exp %b", n, credit[0], n < 4); end
      cyc;
    end
    cmd_vld = '0; dvld = '0;
    #1;
    n_chk++; if (credit[0] !== 1'b0) begin n_fail++; $display("FAIL fill_full_credit got %b exp 0", credit[0]); end
    n_chk++; if (rvld !== 5'b00001) begin n_fail++; $display("FAIL fill_hold_vld got %b exp 00001", rvld); end
    rdy = 5'h1F;
    for (int p = 0; p < 4; p++) begin
      #1;
      n_chk++; if (rvld[0] !== 1'b1 || rdat[0] !== 128'(100 + p) || rtxn[0] !== 8'(8'h10 + p)) begin
        n_fail++; $display("FAIL fill_order %0d got vld %b data %0d txn %h exp 1 %0d %h", p, rvld[0], rdat[0], rtxn[0], 100 + p, 8'h10 + p);
      end
      if (p == 1) begin
        n_chk++; if (credit[0] !== 1'b1) begin n_fail++; $display("FAIL fill_credit_back got %b exp 1", credit[0]); end
      end
      cyc;
    end
    #1;
    n_chk++; if (rvld !== 5'h0 || err !== 1'b0) begin n_fail++; $display("FAIL fill_end got vld %b err %b exp 0 0", rvld, err); end
  endtask

  task automatic test_contention;
    reset_dut;
    for (int r = 0; r < 2; r++) begin
      cmd_vld = 4'hF;
      for (int i = 0; i < 4; i++) begin
        cmd_src[i] = 3'd3; cmd_sel[i] = 1'b0; cmd_txn[i] = 8'(8'h30 + 4 * r + i);
        rdata[2 * i] = 128'(8'hC0 + i);
      end
      cyc;
      cmd_vld = '0;
      cyc;
      dvld = 8'b0101_0101;
      cyc;
      dvld = '0;
      for (int g = 0; g < 4; g++) begin
        #1;
        n_chk++; if (rvld !== 5'b01000 || rtxn[3] !== 8'(8'h30 + 4 * r + g) || rdat[3] !== 128'(8'hC0 + g)) begin
          n_fail++; $display("FAIL rr round %0d slot %0d got vld %b txn %h exp 01000 %h", r, g, rvld, rtxn[3], 8'h30 + 4 * r + g);
        end
        cyc;
      end
      #1;
      n_chk++; if (rvld !== 5'h0) begin n_fail++; $display("FAIL rr_drain %0d got %b exp 0", r, rvld); end
    end
  endtask

  task automatic test_parallel;
    logic [4:0] mask;
    logic [2:0] s;
    for (int r = 0; r < 2; r++) begin
      reset_dut;
      mask = '0;
      cmd_vld = 4'hF;
      for (int i = 0; i < 4; i++) begin
        s = 3'((i + r) % 5);
        mask[s] = 1'b1;
        cmd_src[i] = s; cmd_sel[i] = 1'b1; cmd_txn[i] = 8'(8'h40 + 8 * r + i);
        rdata[2 * i + 1] = 128'(16'h500 + i);
      end
      cyc;
      cmd_vld = '0;
      cyc;
      dvld = 8'b1010_1010;
      cyc;
      dvld = '0;
      #1;
      n_chk++; if (rvld !== mask) begin n_fail++; $display("FAIL par_vld %0d got %b exp %b", r, rvld, mask); end
      for (int i = 0; i < 4; i++) begin
        s = 3'((i + r) % 5);
        n_chk++; if (rtxn[s] !== 8'(8'h40 + 8 * r + i) || rdat[s] !== 128'(16'h500 + i)) begin
          n_fail++; $display("FAIL par_ch %0d got txn %h data %h exp %h %h", s, rtxn[s], rdat[s], 8'h40 + 8 * r + i, 16'h500 + i);
        end
      end
      cyc;
      #1;
      n_chk++; if (rvld !== 5'h0 || err !== 1'b0) begin n_fail++; $display("FAIL par_pop %0d got vld %b err %b exp 0 0", r, rvld, err); end
    end
  endtask

  task automatic test_errors;
    reset_dut;
    cyc; cyc; cyc;
    dvld = 8'b0001_0000; rdata[4] = 128'h77;
    cyc;
    dvld = '0;
    #1;
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_untagged got %b exp 1", err); end
    cyc;
    #1;
    n_chk++; if (rvld !== 5'h0) begin n_fail++; $display("FAIL err_untagged_resp got %b exp 0", rvld); end
    reset_dut;
    rdy = 5'b11110;
    for (int n = 0; n < 5; n++) begin
      cmd_vld = 4'b0001; cmd_src[0] = 3'd0; cmd_sel[0] = 1'b0; cmd_txn[0] = 8'(n);
      dvld = (n >= 2) ? 8'h01 : 8'h00;
      #1;
      if (n == 4) begin
        n_chk++; if (credit[0] !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL err_precredit got credit %b err %b exp 0 0", credit[0], err); end
      end
      cyc;
    end
    cmd_vld = '0; dvld = '0;
    #1;
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_credit got %b exp 1", err); end
    reset_dut;
    cmd_vld = 4'b0100; cmd_src[2] = 3'd6; cmd_sel[2] = 1'b0; cmd_txn[2] = 8'h66;
    cyc;
    cmd_vld = '0;
    #1;
    n_chk++; if (err !== 1'b1 || credit !== 4'hF) begin n_fail++; $display("FAIL err_src got err %b credit %h exp 1 f", err, credit); end
    cyc; cyc; cyc;
    #1;
    n_chk++; if (rvld !== 5'h0) begin n_fail++; $display("FAIL err_src_resp got %b exp 0", rvld); end
    reset_dut;
    cmd_vld = 4'b1000; cmd_src[3] = 3'd1; cmd_sel[3] = 1'b0; cmd_txn[3] = 8'h99;
    cyc;
    cmd_vld = '0;
    cyc;
    #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_missing_early got %b exp 0", err); end
    cyc;
    #1;
    n_chk++; if (err !== 1'b1 || rvld !== 5'h0) begin n_fail++; $display("FAIL err_missing got err %b vld %b exp 1 0", err, rvld); end
  endtask

  task automatic test_reset_midflight;
    reset_dut;
    rdy = 5'b11110;
    cmd_vld = 4'b0001; cmd_src[0] = 3'd0; cmd_sel[0] = 1'b0; cmd_txn[0] = 8'h01;
    cyc;
    cmd_vld = 4'b0010; cmd_src[1] = 3'd1; cmd_sel[1] = 1'b0; cmd_txn[1] = 8'h02;
    cyc;
    cmd_vld = 4'b1010; cmd_txn[1] = 8'h03; cmd_src[3] = 3'd6;
    dvld = 8'h01; rdata[0] = 128'hAA;
    cyc;
    cmd_vld = '0; dvld = '0;
    #1;
    n_chk++; if (rvld !== 5'b00001 || err !== 1'b1) begin n_fail++; $display("FAIL mid_pre got vld %b err %b exp 00001 1", rvld, err); end
    rst = 1'b1; dvld = 8'b0000_0100; rdata[2] = 128'hBB;
    cyc;
    rst = 1'b0;
    #1;
    n_chk++; if (rvld !== 5'h0 || credit !== 4'hF || err !== 1'b0) begin
      n_fail++; $display("FAIL mid_post got vld %b credit %h err %b exp 0 f 0", rvld, credit, err);
    end
    cyc;
    dvld = '0;
    #1;
    n_chk++; if (err !== 1'b0 || rvld !== 5'h0) begin n_fail++; $display("FAIL mid_late got err %b vld %b exp 0 0", err, rvld); end
    cyc;
    #1;
    n_chk++; if (rvld !== 5'h0 || credit !== 4'hF) begin n_fail++; $display("FAIL mid_idle got vld %b credit %h exp 0 f", rvld, credit); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_credit;
    test_contention;
    test_parallel;
    test_errors;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
